// File: rtl/fifo_drain_stage.sv
// fifo_drain_stage: drains a show-ahead FIFO into a two-entry skid buffer and
// presents the buffered words on a ready/valid stream. The pop strobe depends
// only on registered occupancy and the FIFO empty flag, never on out_ready.
//
// Optional feature macro: DRAIN_COUNT_EN (adds the xfer_count port/counter).
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-low reset
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO show-ahead data_out
//   fifo_pop   - pop strobe to the FIFO
//   out_valid  - output word available
//   out_ready  - consumer accepts this cycle
//   out_data   - output word (head of the skid buffer)
//   occupancy  - buffered word count, 0..2
//   xfer_count - completed output transfers (DRAIN_COUNT_EN only)
module fifo_drain_stage #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy
`ifdef DRAIN_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] xfer_count
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_occ;
  state_t           w_occ_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_nxt;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_enq;
  logic             w_deq;
  logic             w_has_room;

  // Room exists only in the legal non-full states; the illegal encoding never pops.
  assign w_has_room = (r_occ == S_EMPTY) || (r_occ == S_ONE);

  assign fifo_pop  = rst & ~fifo_empty & w_has_room;
  assign out_valid = rst & (r_occ != S_EMPTY);
  assign out_data  = rst ? r_head : '0;
  assign occupancy = r_occ;

  assign w_enq = fifo_pop;
  assign w_deq = out_valid & out_ready;

  // Next-state and buffer data steering.
  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_skid_nxt = r_skid;
    case (r_occ)
      S_EMPTY: begin
        if (w_enq) begin
          w_head_nxt = fifo_data;
          w_occ_nxt  = S_ONE;
        end
      end
      S_ONE: begin
        if (w_enq && w_deq) begin
          w_head_nxt = fifo_data;
        end else if (w_enq) begin
          w_skid_nxt = fifo_data;
          w_occ_nxt  = S_TWO;
        end else if (w_deq) begin
          w_occ_nxt  = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_deq) begin
          w_head_nxt = r_skid;
          w_occ_nxt  = S_ONE;
        end
      end
      default: begin
        w_occ_nxt = S_EMPTY;
      end
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ  <= S_EMPTY;
      r_head <= '0;
      r_skid <= '0;
    end else begin
      r_occ  <= w_occ_nxt;
      r_head <= w_head_nxt;
      r_skid <= w_skid_nxt;
    end
  end

`ifdef DRAIN_COUNT_EN
  logic [CNT_WIDTH-1:0] r_xfer_count;

  // Transfer counter, wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_xfer_count <= '0;
    end else if (w_deq) begin
      r_xfer_count <= r_xfer_count + CNT_WIDTH'(1);
    end
  end

  assign xfer_count = r_xfer_count;
`else
  // Counter width is meaningless without the counter.
  logic w_unused_cnt_width;
  assign w_unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule
